mux_sel_seq: RTL

MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

---
 rtl/mux_sel_seq_pkg.sv | 13 +
 rtl/mux_sel_seq_if.sv | 26 ++
 rtl/mux_sel_seq_dwell_cnt.sv | 27 ++
 rtl/mux_sel_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mux_sel_seq_pkg.sv
// Shared definitions for the mux select sequencer: FSM encoding, park select, channel count.
package mux_sel_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_PARK = 2'b11;
  localparam int         NUM_CH   = 3;

endpackage

// File: rtl/mux_sel_seq_if.sv
// Scan request/response bundle between a controller and mux_sel_seq; master drives requests and q.
interface mux_sel_seq_if #(
  parameter int DWELL_W = 4
);
  import mux_sel_seq_pkg::*;

  logic                start;
  logic [NUM_CH-1:0]   mask;
  logic [DWELL_W-1:0]  dwell;
  logic                q;
  logic [1:0]          sel;
  logic [NUM_CH-1:0]   result;
  logic                busy;
  logic                valid;

  modport master (
    output start, mask, dwell, q,
    input  sel, result, busy, valid
  );

  modport slave (
    input  start, mask, dwell, q,
    output sel, result, busy, valid
  );

endinterface

// File: rtl/mux_sel_seq_dwell_cnt.sv
// Dwell down-counter: load has priority over decrement, holds at zero; zero flag is combinational.
module dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_sel_seq.sv
// Scans enabled channels of a 3:1 mux, holding sel for D cycles each and capturing q into result.
// valid pulses n*D+1 cycles after the accepted start; start is ignored outside IDLE.
module mux_sel_seq #(
  parameter int DWELL_W = 4,
  parameter int NUM_CH  = 3
) (
  input  logic          clk,
  input  logic          rst,
  mux_sel_seq_if.slave  bus
);
  import mux_sel_seq_pkg::*;

  state_t             state, state_nxt;
  logic [1:0]         ch;
  logic [2:0]         mask_l;
  logic [DWELL_W-1:0] dwell_m1;
  logic [2:0]         result_r;

  logic [1:0]         first_ch, next_ch;
  logic               first_found, next_found;
  logic [DWELL_W-1:0] start_m1, cnt_val;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic               accept, advance;

  // Counter holds D-1 so a zero dwell naturally collapses to a single cycle.
  assign start_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  // Descending scan leaves the lowest qualifying index as the winner.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.mask[i]) begin
        first_ch    = 2'(i);
        first_found = 1'b1;
      end
      if (mask_l[i] && (i > int'(ch))) begin
        next_ch    = 2'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.sel   = SEL_PARK;
    bus.busy  = 1'b0;
    bus.valid = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = dwell_m1;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (first_found) begin
            state_nxt = DWELL;
            cnt_load  = 1'b1;
            cnt_val   = start_m1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DWELL: begin
        bus.sel  = ch;
        bus.busy = 1'b1;
        if (cnt_zero) begin
          advance = 1'b1;
          if (next_found) begin
            cnt_load = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        bus.valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= '0;
      mask_l   <= '0;
      dwell_m1 <= '0;
      result_r <= '0;
    end else begin
      if (accept) begin
        mask_l   <= bus.mask;
        dwell_m1 <= start_m1;
        ch       <= first_ch;
        result_r <= '0;
      end
      if (advance) begin
        result_r[ch] <= bus.q;
        ch           <= next_ch;
      end
    end
  end

  assign bus.result = result_r;

  dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

endmodule
